// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating an instruction-fetch port and a data port
// onto a single byte-wide memory; all memory-side outputs are registered.
module mem_ctrl #(
    parameter int ADDR_WIDTH = 17,
    parameter int LEN        = 32,
    parameter int BYTE_SIZE  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_req,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    output logic                  inst_done,
    output logic [LEN-1:0]        inst_data,
    input  logic                  data_req,
    input  logic                  data_we,
    input  logic [1:0]            data_size,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [LEN-1:0]        data_wdata,
    output logic                  data_done,
    output logic [LEN-1:0]        data_rdata,
    output logic [ADDR_WIDTH-1:0] mem_vis_addr,
    output logic [1:0]            mem_vis_signal,
    output logic [BYTE_SIZE-1:0]  writen_data,
    input  logic [BYTE_SIZE-1:0]  mem_data
);

    localparam int NB = LEN / BYTE_SIZE;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [1:0] SIG_IDLE  = 2'b00;
    localparam logic [1:0] SIG_WRITE = 2'b01;
    localparam logic [1:0] SIG_RDATA = 2'b10;
    localparam logic [1:0] SIG_RINST = 2'b11;

    typedef enum logic [2:0] {IDLE, INST_RD, DATA_RD, DATA_WR, DONE} state_t;

    state_t                state_q;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         last_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            sig_q;
    logic [BYTE_SIZE-1:0]  wbyte_q;
    logic [LEN-1:0]        wdata_q;
    logic [LEN-1:0]        res_q;
    logic                  last_data_q;
    logic                  inst_done_q;
    logic                  data_done_q;
    logic [LEN-1:0]        inst_data_q;
    logic [LEN-1:0]        data_rdata_q;

    logic                  grant_data;
    logic                  grant_inst;
    logic [CW-1:0]         cnt_nxt;
    logic [LEN-1:0]        res_d;
    logic [BYTE_SIZE-1:0]  wbyte_nxt;

    function automatic logic [CW-1:0] size_last(input logic [1:0] size);
        case (size)
            2'b00:   size_last = CW'(0);
            2'b01:   size_last = CW'(1);
            default: size_last = CW'(NB - 1);
        endcase
    endfunction

    // Ties go to data unless data won the previous grant.
    assign grant_data = data_req && !(inst_req && last_data_q);
    assign grant_inst = inst_req && !grant_data;

    always_comb begin
        cnt_nxt = cnt_q + CW'(1);
        res_d   = res_q;
        res_d[cnt_q*BYTE_SIZE +: BYTE_SIZE] = mem_data;
        wbyte_nxt = wdata_q[cnt_nxt*BYTE_SIZE +: BYTE_SIZE];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_q       <= '0;
            addr_q       <= '0;
            sig_q        <= SIG_IDLE;
            wbyte_q      <= '0;
            wdata_q      <= '0;
            res_q        <= '0;
            last_data_q  <= 1'b0;
            inst_done_q  <= 1'b0;
            data_done_q  <= 1'b0;
            inst_data_q  <= '0;
            data_rdata_q <= '0;
        end else begin
            inst_done_q <= 1'b0;
            data_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    res_q <= '0;
                    if (grant_data) begin
                        last_data_q <= 1'b1;
                        state_q     <= data_we ? DATA_WR : DATA_RD;
                        sig_q       <= data_we ? SIG_WRITE : SIG_RDATA;
                        addr_q      <= data_addr;
                        wdata_q     <= data_wdata;
                        wbyte_q     <= data_we ? data_wdata[BYTE_SIZE-1:0] : '0;
                        last_q      <= size_last(data_size);
                    end else if (grant_inst) begin
                        last_data_q <= 1'b0;
                        state_q     <= INST_RD;
                        sig_q       <= SIG_RINST;
                        addr_q      <= inst_addr;
                        wbyte_q     <= '0;
                        last_q      <= CW'(NB - 1);
                    end
                end
                INST_RD, DATA_RD, DATA_WR: begin
                    if (state_q != DATA_WR) res_q <= res_d;
                    if (cnt_q == last_q) begin
                        state_q     <= DONE;
                        addr_q      <= '0;
                        sig_q       <= SIG_IDLE;
                        wbyte_q     <= '0;
                        inst_done_q <= (state_q == INST_RD);
                        data_done_q <= (state_q != INST_RD);
                        if (state_q == INST_RD) inst_data_q  <= res_d;
                        if (state_q == DATA_RD) data_rdata_q <= res_d;
                    end else begin
                        cnt_q  <= cnt_nxt;
                        addr_q <= addr_q + ADDR_WIDTH'(1);
                        if (state_q == DATA_WR) wbyte_q <= wbyte_nxt;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign inst_done      = inst_done_q;
    assign inst_data      = inst_data_q;
    assign data_done      = data_done_q;
    assign data_rdata     = data_rdata_q;
    assign mem_vis_addr   = addr_q;
    assign mem_vis_signal = sig_q;
    assign writen_data    = wbyte_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte memory, reference memory model, table vectors,
// hand-written arbitration/reset sequences and randomized transactions.
module tb_mem_ctrl;

    localparam int AW    = 17;
    localparam int MSIZE = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          inst_req = 1'b0;
    logic [AW-1:0] inst_addr = '0;
    logic          inst_done;
    logic [31:0]   inst_data;
    logic          data_req = 1'b0;
    logic          data_we = 1'b0;
    logic [1:0]    data_size = 2'b00;
    logic [AW-1:0] data_addr = '0;
    logic [31:0]   data_wdata = '0;
    logic          data_done;
    logic [31:0]   data_rdata;
    logic [AW-1:0] mem_vis_addr;
    logic [1:0]    mem_vis_signal;
    logic [7:0]    writen_data;
    logic [7:0]    mem_data;

    logic [7:0] mem     [0:MSIZE-1];
    logic [7:0] ref_mem [0:MSIZE-1];

    int checks = 0;
    int errors = 0;

    mem_ctrl #(.ADDR_WIDTH(AW), .LEN(32), .BYTE_SIZE(8)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_done(inst_done), .inst_data(inst_data),
        .data_req(data_req), .data_we(data_we), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_done(data_done), .data_rdata(data_rdata),
        .mem_vis_addr(mem_vis_addr), .mem_vis_signal(mem_vis_signal),
        .writen_data(writen_data), .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    assign mem_data = mem[mem_vis_addr];

    always @(posedge clk) begin
        if (mem_vis_signal == 2'b01) mem[mem_vis_addr] <= writen_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic poke(input int a, input logic [7:0] d);
        mem[a]     = d;
        ref_mem[a] = d;
    endtask

    function automatic int nbytes(input bit is_inst, input logic [1:0] size);
        if (is_inst) return 4;
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [AW-1:0] a, input int n);
        logic [31:0] r = '0;
        for (int k = 0; k < n; k++)
            r = r | (32'(ref_mem[(int'(a) + k) % MSIZE]) << (8 * k));
        return r;
    endfunction

    task automatic model_store(input logic [AW-1:0] a, input int n, input logic [31:0] wd);
        for (int k = 0; k < n; k++)
            ref_mem[(int'(a) + k) % MSIZE] = 8'((wd >> (8 * k)) & 32'hFF);
    endtask

    // One complete transaction with cycle-exact protocol checks; cycle 0 is the request cycle.
    task automatic run_txn(input bit is_inst, input bit we, input logic [1:0] size,
                           input logic [AW-1:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp);
        int          n;
        logic [1:0]  exp_sig;
        n       = nbytes(is_inst, size);
        exp_sig = is_inst ? 2'b11 : (we ? 2'b01 : 2'b10);
        @(negedge clk);
        if (is_inst) begin
            inst_req  = 1'b1;
            inst_addr = addr;
        end else begin
            data_req   = 1'b1;
            data_we    = we;
            data_size  = size;
            data_addr  = addr;
            data_wdata = wdata;
        end
        @(negedge clk);
        inst_addr  = AW'($urandom);
        data_addr  = AW'($urandom);
        data_wdata = $urandom;
        data_size  = 2'($urandom);
        data_we    = 1'($urandom);
        for (int k = 0; k < n; k++) begin
            chk("busy_sig", 32'(mem_vis_signal), 32'(exp_sig));
            chk("busy_addr", 32'(mem_vis_addr), (int'(addr) + k) % MSIZE);
            chk("busy_nodone", {30'd0, inst_done, data_done}, 32'd0);
            if (!is_inst && we)
                chk("wr_byte", 32'(writen_data), (wdata >> (8 * k)) & 32'hFF);
            if (k < n - 1) @(negedge clk);
        end
        @(negedge clk);
        chk("done_pulse", {30'd0, inst_done, data_done}, is_inst ? 32'd2 : 32'd1);
        chk("done_sig", 32'(mem_vis_signal), 32'd0);
        if (is_inst)      chk("inst_data", inst_data, exp);
        else if (!we)     chk("data_rdata", data_rdata, exp);
        inst_req = 1'b0;
        data_req = 1'b0;
        @(negedge clk);
        chk("post_nodone", {30'd0, inst_done, data_done}, 32'd0);
        chk("post_idle", {13'd0, mem_vis_addr, mem_vis_signal}, 32'd0);
        chk("post_wbyte", 32'(writen_data), 32'd0);
        if (is_inst)  chk("inst_hold", inst_data, exp);
        else if (!we) chk("rdata_hold", data_rdata, exp);
    endtask

    typedef struct {
        bit          is_inst;
        bit          we;
        logic [1:0]  size;
        logic [AW-1:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[5];

    initial begin
        byte unsigned order[$];
        int writes;
        int both;
        int cyc;

        for (int i = 0; i < MSIZE; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        poke('h100, 8'h13); poke('h101, 8'h05); poke('h102, 8'h00); poke('h103, 8'h00);
        poke('h2002, 8'h00); poke('h2003, 8'h00);
        poke('h1FFFE, 8'hAA); poke('h1FFFF, 8'hBB); poke('h0, 8'hCC); poke('h1, 8'hDD);
        poke('h10, 8'hF0);

        vecs[0] = '{1'b1, 1'b0, 2'b00, 17'h00100, 32'h0,        32'h00000513};
        vecs[1] = '{1'b0, 1'b1, 2'b01, 17'h02000, 32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b0, 1'b0, 2'b10, 17'h02000, 32'h0,        32'h0000BEEF};
        vecs[3] = '{1'b0, 1'b0, 2'b10, 17'h1FFFE, 32'h0,        32'hDDCCBBAA};
        vecs[4] = '{1'b0, 1'b0, 2'b00, 17'h00010, 32'h0,        32'h000000F0};

        repeat (2) @(negedge clk);
        chk("rst_done", {30'd0, inst_done, data_done}, 32'd0);
        chk("rst_inst_data", inst_data, 32'd0);
        chk("rst_data_rdata", data_rdata, 32'd0);
        chk("rst_bus", {13'd0, mem_vis_addr, mem_vis_signal}, 32'd0);
        chk("rst_wbyte", 32'(writen_data), 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_txn(vecs[i].is_inst, vecs[i].we, vecs[i].size, vecs[i].addr,
                    vecs[i].wdata, vecs[i].exp);
            if (vecs[i].we)
                model_store(vecs[i].addr, nbytes(1'b0, vecs[i].size), vecs[i].wdata);
        end

        // Both requesters held from reset release: data first, then alternating.
        @(negedge clk);
        rst        = 1'b1;
        inst_req   = 1'b1;
        inst_addr  = 17'h00100;
        data_req   = 1'b1;
        data_we    = 1'b1;
        data_size  = 2'b00;
        data_addr  = 17'h00040;
        data_wdata = 32'h00000077;
        @(negedge clk);
        rst    = 1'b0;
        writes = 0;
        both   = 0;
        cyc    = 0;
        while (order.size() < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (mem_vis_signal == 2'b01) writes++;
            if (inst_done && data_done) both++;
            if (data_done) order.push_back(8'h44);
            else if (inst_done) order.push_back(8'h49);
            if (order.size() == 4) begin
                inst_req = 1'b0;
                data_req = 1'b0;
            end
        end
        inst_req = 1'b0;
        data_req = 1'b0;
        chk("tie_count", order.size(), 32'd4);
        while (order.size() < 4) order.push_back(8'h00);
        chk("tie_0", 32'(order[0]), 32'h44);
        chk("tie_1", 32'(order[1]), 32'h49);
        chk("tie_2", 32'(order[2]), 32'h44);
        chk("tie_3", 32'(order[3]), 32'h49);
        chk("tie_writes", writes, 32'd2);
        chk("tie_both", both, 32'd0);
        chk("tie_fetch_data", inst_data, 32'h00000513);
        ref_mem['h40] = 8'h77;
        @(negedge clk);

        // Word store aborted by reset in its third busy cycle.
        poke('h300, 8'h11); poke('h301, 8'h22); poke('h302, 8'h33); poke('h303, 8'h44);
        @(negedge clk);
        data_req   = 1'b1;
        data_we    = 1'b1;
        data_size  = 2'b10;
        data_addr  = 17'h00300;
        data_wdata = 32'hA5B6C7D8;
        repeat (3) @(negedge clk);
        chk("abort_pre_addr", 32'(mem_vis_addr), 32'h302);
        rst = 1'b1;
        #1;
        chk("abort_bus", {13'd0, mem_vis_addr, mem_vis_signal}, 32'd0);
        chk("abort_wbyte", 32'(writen_data), 32'd0);
        data_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort_nodone", {30'd0, inst_done, data_done}, 32'd0);
        end
        rst = 1'b0;
        chk("abort_m300", 32'(mem['h300]), 32'hD8);
        chk("abort_m301", 32'(mem['h301]), 32'hC7);
        chk("abort_m302", 32'(mem['h302]), 32'h33);
        chk("abort_m303", 32'(mem['h303]), 32'h44);
        chk("abort_rdata", data_rdata, 32'd0);
        chk("abort_inst_data", inst_data, 32'd0);
        ref_mem['h300] = 8'hD8;
        ref_mem['h301] = 8'hC7;
        run_txn(1'b0, 1'b0, 2'b10, 17'h00300, 32'h0, model_load(17'h00300, 4));

        for (int t = 0; t < 60; t++) begin
            int            kind;
            logic [1:0]    size;
            logic [AW-1:0] addr;
            logic [31:0]   wd;
            int            n;
            kind = $urandom_range(0, 2);
            size = 2'($urandom);
            addr = ($urandom_range(0, 3) == 0) ? AW'(MSIZE - 4 + $urandom_range(0, 3))
                                                : AW'($urandom_range(0, 255) + 'h4000);
            wd   = $urandom;
            n    = nbytes(kind == 0, size);
            run_txn(kind == 0, kind == 2, size, addr, wd, model_load(addr, n));
            if (kind == 2) model_store(addr, n, wd);
        end

        for (int a = 'h4000; a < 'h4100; a += 4)
            run_txn(1'b0, 1'b0, 2'b11, AW'(a), 32'h0, model_load(AW'(a), 4));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 17, memory byte address width; LEN, default 32, word width; BYTE_SIZE, default 8, memory data width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 inst_req  input  1  instruction fetch request, level, held until inst_done.
REQ-005 inst_addr  input  ADDR_WIDTH  fetch byte address, stable while inst_req=1.
REQ-006 inst_done  output  1  one-cycle pulse: fetch complete.
REQ-007 inst_data  output  LEN  fetched word, valid when inst_done=1.
REQ-008 data_req  input  1  data access request, level, held until data_done.
REQ-009 data_we  input  1  1=store, 0=load; stable while data_req=1.
REQ-010 data_size  input  2  00=1 byte, 01=2 bytes, 10/11=4 bytes.
REQ-011 data_addr  input  ADDR_WIDTH  data byte address.
REQ-012 data_wdata  input  LEN  store data, little-endian, low bytes used.
REQ-013 data_done  output  1  one-cycle pulse: data access complete.
REQ-014 data_rdata  output  LEN  load result, zero-extended, valid when data_done=1.
REQ-015 mem_vis_addr  output  ADDR_WIDTH  byte address to main memory.
REQ-016 mem_vis_signal  output  2  00=IDLE, 01=WRITE, 10=READ_DATA, 11=READ_INST.
REQ-017 writen_data  output  BYTE_SIZE  byte to write.
REQ-018 mem_data  input  BYTE_SIZE  combinational read byte; valid in the same cycle as mem_vis_addr.

Function
REQ-019 The FSM SHALL have states IDLE, INST_RD, DATA_RD, DATA_WR, DONE.
REQ-020 In IDLE, at a rising edge, if exactly one req=1, the FSM SHALL grant it.
- Fetch grant -> INST_RD.
- Data grant with data_we=0 -> DATA_RD; with data_we=1 -> DATA_WR.
- The byte counter SHALL reset to 0.
REQ-021 If both req=1 in IDLE, grant SHALL go to data, except when the last grant was data, in which case it SHALL go to inst.
REQ-022 The grant-history bit SHALL reset to inst, so data wins the first tie.
REQ-023 At grant, the controller SHALL latch address, size, we and wdata; later requester changes SHALL have no effect on the transaction.
REQ-024 Byte count N SHALL be 4 for fetch, and 1/2/4 for data per data_size.
REQ-025 In a busy state, with counter value i, the controller SHALL drive:
- mem_vis_addr = (latched addr + i) mod 2^ADDR_WIDTH;
- mem_vis_signal = READ_INST, READ_DATA or WRITE according to the state;
- writen_data = latched wdata byte i (DATA_WR only).
REQ-026 In DATA_RD/INST_RD, each cycle SHALL capture mem_data into result byte i (bits 8i+7:8i) at the rising edge.
REQ-027 Bytes above N in the result SHALL be zero.
REQ-028 After the edge at which i=N-1, the FSM SHALL enter DONE; the busy state lasts exactly N cycles.
REQ-029 In DONE, the controller SHALL:
- pulse the done output of the granted requester for exactly one cycle, with the result on inst_data/data_rdata;
- drive mem_vis_signal=IDLE;
- ignore requests;
- move to IDLE on the next edge.
REQ-030 Latency SHALL be as follows, where request first sampled at edge 0 means the request is high in cycle 0 and sampled by the edge that ends it:
- busy in cycles 1..N;
- done in cycle N+1;
- next request sampled at the end of cycle N+2.
REQ-031 A requester still asserting req in cycle N+2 SHALL be treated as a new request.
REQ-032 Outside busy states, the controller SHALL drive mem_vis_signal=IDLE, mem_vis_addr=0 and writen_data=0, so that no spurious write occurs.
REQ-033 inst_data/data_rdata SHALL hold their last values after done; they are valid only during done.
REQ-034 Misaligned addresses SHALL be legal; no alignment fault.

Reset
REQ-035 On rst=1 the controller SHALL asynchronously force:
- state=IDLE, counter=0, grant history=inst;
- inst_done=0, data_done=0, inst_data=0, data_rdata=0;
- mem_vis_signal=IDLE, mem_vis_addr=0, writen_data=0.
REQ-036 Reset during a busy state SHALL abort the transaction with no done pulse.
- Store bytes already written at completed edges remain in memory; no further bytes are written.
REQ-037 After rst falls, the first grant SHALL occur at the first rising edge with a req high.

Verification
REQ-038 Fetch: memory 0x100..0x103 = 13 05 00 00, inst_req, inst_addr=0x100 -> READ_INST at 0x100..0x103 in cycles 1-4; inst_done in cycle 5 with inst_data=0x00000513.
REQ-039 Store then load: data_we=1, size=01, addr=0x2000, wdata=0xDEADBEEF -> WRITE at 0x2000 (EF), then 0x2001 (BE); data_done in cycle 3. Then load size=10 at 0x2000 -> data_rdata=0x0000BEEF.
REQ-040 Tie: inst_req and data_req both high from reset release, both held after done -> order data, inst, data, inst; no cycle drives WRITE during inst service.
REQ-041 Wrap: load size=10 at addr 0x1FFFE -> addresses 0x1FFFE, 0x1FFFF, 0x00000, 0x00001; bytes assembled in that order.
REQ-042 Reset mid-store: word store to 0x300, rst asserted during cycle 3 -> no data_done; mem_vis_signal=IDLE immediately; 0x300-0x301 updated, 0x302-0x303 unchanged.
REQ-043 Byte load: size=00 at 0x10, memory 0xF0 -> one busy cycle; data_rdata=0x000000F0 in cycle 2.
